csr_counter_bank: RTL and testbench

//  Parametrised machine counter bank: mcycle, minstret and NUM_HPM event counters
//  (mhpmcounter3..), plus mcountinhibit and mhpmevent selectors.

---
 rtl/csr_cnt_pkg.sv | 65 ++++++
 rtl/csr_counter_cell.sv | 50 +++++
 rtl/csr_counter_bank.sv | 149 ++++++++++++++
 tb/tb_csr_counter_bank.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/csr_cnt_pkg.sv
// Shared CSR addresses, inhibit bit positions and address decode for the
// machine counter bank.
package csr_cnt_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;

    localparam int INH_CY   = 0;
    localparam int INH_IR   = 2;
    localparam int INH_HPM3 = 3;

    localparam int CNT_CY   = 0;
    localparam int CNT_IR   = 1;
    localparam int CNT_HPM3 = 2;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_INHIBIT,
        REG_EVENT,
        REG_CNT_LO,
        REG_CNT_HI
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic       user;
        logic [4:0] off;
    } csr_dec_t;

    function automatic logic is_hpm_addr(input logic [11:0] addr, input logic [11:0] base);
        return (addr >= base + 12'd3) && (addr <= base + 12'd31);
    endfunction

    // Offset 1 of each counter bank is the time CSR, which lives elsewhere.
    function automatic csr_dec_t decode_addr(input logic [11:0] addr, input logic has_hi);
        csr_dec_t d;
        d.kind = REG_NONE;
        d.user = 1'b0;
        d.off  = addr[4:0];
        if (addr == CSR_MCOUNTINHIBIT) begin
            d.kind = REG_INHIBIT;
        end else if (is_hpm_addr(addr, CSR_MCOUNTINHIBIT)) begin
            d.kind = REG_EVENT;
        end else if (addr[4:0] != 5'd1) begin
            if (addr[11:5] == CSR_MCYCLE[11:5]) begin
                d.kind = REG_CNT_LO;
            end else if (has_hi && (addr[11:5] == CSR_MCYCLEH[11:5])) begin
                d.kind = REG_CNT_HI;
            end else if (addr[11:5] == CSR_CYCLE[11:5]) begin
                d.kind = REG_CNT_LO;
                d.user = 1'b1;
            end else if (has_hi && (addr[11:5] == CSR_CYCLEH[11:5])) begin
                d.kind = REG_CNT_HI;
                d.user = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/csr_counter_cell.sv
// One wrapping counter with split-half CSR write; a write always wins over
// the increment in the same cycle.
module csr_counter_cell #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [XLEN-1:0]  wdata,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [63:0]      cur64;
    logic [63:0]      wdata64;
    logic [63:0]      new64;

    // Merge in a 64-bit view so bits at or above CNT_W simply fall away.
    always_comb begin
        cur64   = 64'(cnt_q);
        wdata64 = 64'(wdata);
        new64   = cur64;
        if (wr_hi) begin
            new64 = {wdata64[31:0], cur64[31:0]};
        end else if (wr_lo) begin
            new64 = (XLEN == 32) ? {cur64[63:32], wdata64[31:0]} : wdata64;
        end
        cnt_d = cnt_q;
        if (wr_lo || wr_hi) begin
            cnt_d = new64[CNT_W-1:0];
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_counter_bank.sv
// Machine counter bank: mcycle, minstret and hpm event counters with
// mcountinhibit, mhpmevent selectors, lo/hi access and user shadows.
module csr_counter_bank
    import csr_cnt_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CNT_W   = 64,
    parameter int NUM_HPM = 4,
    parameter int NUM_EVT = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               stall,
    input  logic               flush,
    input  logic               retire,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [11:0]        csr_addr,
    input  logic               csr_we,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               csr_hit
);

    localparam int          NUM_CNT  = 2 + NUM_HPM;
    localparam int          HPM_N    = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int          EVT_W    = $clog2(NUM_EVT + 1);
    localparam logic        HAS_HI   = (XLEN == 32);
    localparam logic [31:0] INH_MASK = 32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

    csr_dec_t                      dec;
    int                            hpm_idx;
    logic [31:0]                   inh_q, inh_d;
    logic                          inh_we;
    logic [EVT_W-1:0]              sel_q [HPM_N];
    logic [EVT_W-1:0]              sel_d [HPM_N];
    logic [HPM_N-1:0]              evt_we;
    logic                          first_cyc_q, first_cyc_d;
    logic [NUM_CNT-1:0]            inc;
    logic [NUM_CNT-1:0]            wr_lo;
    logic [NUM_CNT-1:0]            wr_hi;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
    logic [NUM_CNT-1:0][63:0]      cnt64;
    logic [63:0]                   rd_val;

    assign dec     = decode_addr(csr_addr, HAS_HI);
    assign hpm_idx = int'(dec.off) - int'(CSR_MHPMCOUNTER3[4:0]);

    // Read mux and per-register write strobes; user shadows never write.
    always_comb begin
        csr_hit   = 1'b0;
        csr_rdata = '0;
        inh_we    = 1'b0;
        evt_we    = '0;
        wr_lo     = '0;
        wr_hi     = '0;
        rd_val    = '0;
        unique case (dec.kind)
            REG_INHIBIT: begin
                csr_hit   = 1'b1;
                csr_rdata = XLEN'(inh_q);
                inh_we    = csr_we;
            end
            REG_EVENT: begin
                csr_hit = 1'b1;
                for (int j = 0; j < NUM_HPM; j++) begin
                    if (hpm_idx == j) begin
                        csr_rdata = XLEN'(sel_q[j]);
                        evt_we[j] = csr_we;
                    end
                end
            end
            REG_CNT_LO, REG_CNT_HI: begin
                csr_hit = 1'b1;
                for (int k = 0; k < NUM_CNT; k++) begin
                    if ((dec.off == CSR_MCYCLE[4:0] && k == CNT_CY) ||
                        (dec.off == CSR_MINSTRET[4:0] && k == CNT_IR) ||
                        (hpm_idx >= 0 && hpm_idx < NUM_HPM && k == CNT_HPM3 + hpm_idx)) begin
                        rd_val   = cnt64[k];
                        wr_lo[k] = csr_we && !dec.user && (dec.kind == REG_CNT_LO);
                        wr_hi[k] = csr_we && !dec.user && (dec.kind == REG_CNT_HI);
                    end
                end
                csr_rdata = (dec.kind == REG_CNT_HI) ? XLEN'(rd_val >> 32) : XLEN'(rd_val);
            end
            default: ;
        endcase
    end

    always_comb begin
        inh_d = inh_q;
        if (inh_we) begin
            inh_d = csr_wdata[31:0] & INH_MASK;
        end
        first_cyc_d = 1'b1;
        for (int j = 0; j < HPM_N; j++) begin
            sel_d[j] = sel_q[j];
            if (evt_we[j]) begin
                sel_d[j] = csr_wdata[EVT_W-1:0];
            end
        end
    end

    // Selector values outside 1..NUM_EVT match no event line, so the counter holds.
    always_comb begin
        inc         = '0;
        inc[CNT_CY] = !inh_q[INH_CY];
        inc[CNT_IR] = !inh_q[INH_IR] && first_cyc_q && retire && !stall && !flush;
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int e = 0; e < NUM_EVT; e++) begin
                if (sel_q[i] == EVT_W'(e + 1) && evt_i[e]) begin
                    inc[CNT_HPM3 + i] = !inh_q[INH_HPM3 + i] && first_cyc_q;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inh_q       <= '0;
            first_cyc_q <= 1'b0;
            for (int j = 0; j < HPM_N; j++) begin
                sel_q[j] <= '0;
            end
        end else begin
            inh_q       <= inh_d;
            first_cyc_q <= first_cyc_d;
            for (int j = 0; j < HPM_N; j++) begin
                sel_q[j] <= sel_d[j];
            end
        end
    end

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        csr_counter_cell #(
            .XLEN  (XLEN),
            .CNT_W (CNT_W)
        ) u_cell (
            .clk   (CLK),
            .rst_n (RST_N),
            .inc   (inc[k]),
            .wr_lo (wr_lo[k]),
            .wr_hi (wr_hi[k]),
            .wdata (csr_wdata),
            .cnt_o (cnt[k])
        );
        assign cnt64[k] = 64'(cnt[k]);
    end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed bench for csr_counter_bank at default parameters (XLEN=32,
// CNT_W=64, NUM_HPM=4, NUM_EVT=8) with hand-computed expectations.
`timescale 1ns/1ps
module tb_csr_counter_bank;

    logic        CLK;
    logic        RST_N;
    logic        stall;
    logic        flush;
    logic        retire;
    logic [7:0]  evt_i;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;

    int check_count = 0;
    int pass_count  = 0;

    csr_counter_bank #(
        .XLEN    (32),
        .CNT_W   (64),
        .NUM_HPM (4),
        .NUM_EVT (8)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .stall     (stall),
        .flush     (flush),
        .retire    (retire),
        .evt_i     (evt_i),
        .csr_addr  (csr_addr),
        .csr_we    (csr_we),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .csr_hit   (csr_hit)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are held across exactly one rising edge, then returned to idle.
    task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                                 input logic ret, input logic stl, input logic fls, input logic [7:0] ev);
        csr_we    = we;
        csr_addr  = addr;
        csr_wdata = wdata;
        retire    = ret;
        stall     = stl;
        flush     = fls;
        evt_i     = ev;
        @(negedge CLK);
        csr_we = 1'b0;
        retire = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        evt_i  = '0;
    endtask

    task automatic checkCsr(input string tag, input logic [11:0] addr,
                            input logic [31:0] exp_data, input logic exp_hit);
        csr_addr = addr;
        #1;
        checkOutput({tag, "_data"}, 64'(csr_rdata), 64'(exp_data));
        checkOutput({tag, "_hit"}, 64'(csr_hit), 64'(exp_hit));
    endtask

    initial begin
        RST_N     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        retire    = 1'b0;
        evt_i     = '0;
        csr_addr  = '0;
        csr_we    = 1'b0;
        csr_wdata = '0;

        // Reset state, then 10 edges with retire high
        repeat (2) @(negedge CLK);
        checkCsr("rst_mcycle", 12'hB00, 32'h0, 1'b1);
        checkCsr("rst_minstret", 12'hB02, 32'h0, 1'b1);
        checkCsr("rst_inhibit", 12'h320, 32'h0, 1'b1);
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 12'hB00, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        checkCsr("t1_mcycle", 12'hB00, 32'd10, 1'b1);
        checkCsr("t1_mcycleh", 12'hB80, 32'd0, 1'b1);
        checkCsr("t1_minstret", 12'hB02, 32'd9, 1'b1);

        // Stall and flush block retirement counting
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 12'hB00, 32'h0, 1'b1, 1'b1, 1'b0, 8'h0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 12'hB00, 32'h0, 1'b1, 1'b0, 1'b1, 8'h0);
        checkCsr("t2_minstret_held", 12'hB02, 32'd9, 1'b1);
        applyStimulus(1'b0, 12'hB00, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        checkCsr("t2_minstret_resume", 12'hB02, 32'd10, 1'b1);

        // Low/high half writes and carry into the high half
        applyStimulus(1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'h0);
        applyStimulus(1'b1, 12'hB80, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
        applyStimulus(1'b0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
        checkCsr("t3_mcycle_lo", 12'hB00, 32'h0, 1'b1);
        checkCsr("t3_mcycle_hi", 12'hB80, 32'h1, 1'b1);
        applyStimulus(1'b1, 12'hB82, 32'h5, 1'b0, 1'b0, 1'b0, 8'h0);
        checkCsr("t3_minstreth", 12'hB82, 32'h5, 1'b1);
        checkCsr("t3_minstret_lo_kept", 12'hB02, 32'd10, 1'b1);
        checkCsr("t3_instreth_shadow", 12'hC82, 32'h5, 1'b1);

        // Event selection, inhibit and out-of-range selector
        applyStimulus(1'b1, 12'h323, 32'h2, 1'b0, 1'b0, 1'b0, 8'h0);
        checkCsr("t4_sel3", 12'h323, 32'h2, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0, 8'h02);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0, 8'h01);
        checkCsr("t4_hpm3", 12'hB03, 32'd5, 1'b1);
        applyStimulus(1'b1, 12'h320, 32'h8, 1'b0, 1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0, 8'h02);
        checkCsr("t4_hpm3_inhibited", 12'hB03, 32'd5, 1'b1);
        checkCsr("t4_inhibit", 12'h320, 32'h8, 1'b1);
        applyStimulus(1'b1, 12'h324, 32'h9, 1'b0, 1'b0, 1'b0, 8'h0);
        checkCsr("t4_sel4", 12'h324, 32'h9, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0, 8'hFF);
        checkCsr("t4_hpm4_bad_sel", 12'hB04, 32'd0, 1'b1);
        applyStimulus(1'b1, 12'h320, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'h0);
        checkCsr("t4_inhibit_mask", 12'h320, 32'h7D, 1'b1);
        applyStimulus(1'b1, 12'hB07, 32'h77, 1'b0, 1'b0, 1'b0, 8'h0);
        checkCsr("t4_hpm7_unimpl", 12'hB07, 32'h0, 1'b1);

        // Shadow writes ignored, unimplemented address, write beats retire
        applyStimulus(1'b1, 12'h320, 32'h1, 1'b0, 1'b0, 1'b0, 8'h0);
        applyStimulus(1'b1, 12'hB00, 32'h100, 1'b0, 1'b0, 1'b0, 8'h0);
        applyStimulus(1'b1, 12'hC00, 32'h55, 1'b0, 1'b0, 1'b0, 8'h0);
        checkCsr("t5_cycle_shadow", 12'hC00, 32'h100, 1'b1);
        checkCsr("t5_mcycle", 12'hB00, 32'h100, 1'b1);
        checkCsr("t5_unimpl", 12'h7FF, 32'h0, 1'b0);
        applyStimulus(1'b1, 12'h320, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
        applyStimulus(1'b1, 12'hB02, 32'hABCD, 1'b1, 1'b0, 1'b0, 8'h0);
        checkCsr("t5_minstret_wr", 12'hB02, 32'hABCD, 1'b1);
        checkCsr("t5_instret_shadow", 12'hC02, 32'hABCD, 1'b1);

        // Asynchronous reset mid-count, then re-armed counting
        applyStimulus(1'b1, 12'hB80, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
        applyStimulus(1'b1, 12'hB00, 32'h1234, 1'b0, 1'b0, 1'b0, 8'h0);
        checkCsr("t6_mcycle_pre", 12'hB00, 32'h1234, 1'b1);
        RST_N = 1'b0;
        #1;
        checkCsr("t6_mcycle_rst", 12'hB00, 32'h0, 1'b1);
        checkCsr("t6_mcycleh_rst", 12'hB80, 32'h0, 1'b1);
        checkCsr("t6_minstret_rst", 12'hB02, 32'h0, 1'b1);
        checkCsr("t6_hpm3_rst", 12'hB03, 32'h0, 1'b1);
        checkCsr("t6_sel3_rst", 12'h323, 32'h0, 1'b1);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 12'hB00, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        checkCsr("t6_mcycle_resume", 12'hB00, 32'd3, 1'b1);
        checkCsr("t6_minstret_resume", 12'hB02, 32'd2, 1'b1);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
